fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ requesters. It sits directly in front of the FIFO: each cycle it selects at most one requester, drives that requester's data onto the FIFO write port, and returns a one-hot grant. Burst locking lets the current owner keep the port for up to MAX_BURST consecutive writes, so short packets stay contiguous in the FIFO while every other requester still gets bounded access.

---
 rtl/fifo_wr_arbiter.sv | 89 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port, with burst locking.
// Revision 1.0
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [SRC_W-1:0]              fifo_wr_src
);

  localparam int         REQ_PAD = 1 << SRC_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic [SRC_W-1:0]   last;
  logic [3:0]         burst_cnt;
  logic [REQ_PAD-1:0] req_ext;
  logic [SRC_W-1:0]   rr_win;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W:0]     cand;
  logic               lock;
  logic               grant_any;

  // Padding lets req be indexed by any SRC_W-bit value when NUM_REQ is not a power of two.
  assign req_ext = REQ_PAD'(req);

  // Scan from the farthest candidate down so the nearest requester after last wins.
  always_comb begin
    rr_win = '0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      if (req_ext[cand[SRC_W-1:0]]) begin
        rr_win = cand[SRC_W-1:0];
      end
    end
  end

  assign lock      = (burst_cnt != 4'd0) && req_ext[last] && (burst_cnt < MAX_CNT);
  assign grant_any = !rst && !fifo_full && (req != '0);
  assign winner    = lock ? last : rr_win;

  always_comb begin
    gnt          = '0;
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (winner == SRC_W'(i))) begin
        gnt[i]       = 1'b1;
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_wr_en  = grant_any;
  assign fifo_wr_src = grant_any ? winner : '0;

  // Backpressure holds the state so a burst survives a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= SRC_W'(NUM_REQ - 1);
      burst_cnt <= 4'd0;
    end else if (!fifo_full) begin
      if (req == '0) begin
        burst_cnt <= 4'd0;
      end else begin
        last <= winner;
        if ((winner == last) && (burst_cnt < MAX_CNT)) begin
          burst_cnt <= burst_cnt + 4'd1;
        end else begin
          burst_cnt <= 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Revision 1.0
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0]    fifo_wr_src;

  int checks = 0;
  int errors = 0;

  int m_last = N - 1;
  int m_cnt  = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_src (fifo_wr_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference winner (-1 = no grant) from the arbitration rules.
  function automatic int model_win();
    int w;
    w = -1;
    if (!rst && !fifo_full && (req != '0)) begin
      if (m_cnt > 0 && req[m_last] && m_cnt < MB) begin
        w = m_last;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        end
      end
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_last <= N - 1;
      m_cnt  <= 0;
    end else if (!fifo_full) begin
      if (req == '0) begin
        m_cnt <= 0;
      end else begin
        m_cnt  <= (model_win() == m_last && m_cnt < MB) ? m_cnt + 1 : 1;
        m_last <= model_win();
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    w  = model_win();
    eg = (w >= 0) ? N'(1 << w) : '0;
    ed = (w >= 0) ? req_data[w*DW +: DW] : '0;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_wr_en", 32'(fifo_wr_en), 32'(w >= 0));
    chk("model_wr_data", 32'(fifo_wr_data), 32'(ed));
    chk("model_wr_src", 32'(fifo_wr_src), (w >= 0) ? 32'(w) : 32'd0);
    chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("gnt_in_req", 32'((gnt & ~req) == '0), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one cycle against literal expectations, then advances past the next edge.
  task automatic expect_cycle(input string name, input logic en, input logic [1:0] src);
    @(negedge clk);
    chk({name, "_en"}, 32'(fifo_wr_en), 32'(en));
    chk({name, "_src"}, 32'(fifo_wr_src), en ? 32'(src) : 32'd0);
    chk({name, "_gnt"}, 32'(gnt), en ? 32'(4'b0001 << src) : 32'd0);
    chk({name, "_data"}, 32'(fifo_wr_data), en ? 32'(8'hA0 + src) : 32'd0);
    tick();
  endtask

  int s1[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    fifo_full = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    expect_cycle("reset", 1'b0, 2'd0);
    expect_cycle("reset2", 1'b0, 2'd0);

    // Full-load rotation with bursts of four.
    rst = 1'b0;
    for (int i = 0; i < 17; i++) expect_cycle("rotate", 1'b1, 2'(s1[i]));

    // Sole requester keeps being served across burst wraps.
    req = 4'b0100;
    for (int i = 0; i < 10; i++) expect_cycle("sole", 1'b1, 2'd2);

    // Backpressure mid-burst keeps the lock.
    rst = 1'b1; req = 4'b1111;
    expect_cycle("rst_mid", 1'b0, 2'd0);
    rst = 1'b0;
    expect_cycle("pre_full", 1'b1, 2'd0);
    expect_cycle("pre_full", 1'b1, 2'd0);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle("full", 1'b0, 2'd0);
    fifo_full = 1'b0;
    expect_cycle("post_full", 1'b1, 2'd0);
    expect_cycle("post_full", 1'b1, 2'd0);
    expect_cycle("post_full", 1'b1, 2'd1);
    expect_cycle("post_full", 1'b1, 2'd1);

    // Owner drops out mid-burst.
    req = 4'b1001;
    expect_cycle("drop_owner", 1'b1, 2'd3);

    // Idle clears the burst count.
    req = 4'b0010;
    expect_cycle("single", 1'b1, 2'd1);
    req = 4'b0000;
    expect_cycle("idle", 1'b0, 2'd0);
    expect_cycle("idle", 1'b0, 2'd0);
    req = 4'b0011;
    expect_cycle("after_idle", 1'b1, 2'd0);

    // Reset during a burst of owner 2.
    req = 4'b0100;
    expect_cycle("burst2", 1'b1, 2'd2);
    expect_cycle("burst2", 1'b1, 2'd2);
    req = 4'b1111;
    expect_cycle("burst2", 1'b1, 2'd2);
    rst = 1'b1;
    expect_cycle("rst_burst", 1'b0, 2'd0);
    rst = 1'b0;
    expect_cycle("post_rst", 1'b1, 2'd0);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      req       = 4'($urandom);
      req_data  = 32'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
